// File: rtl/alu_cmd_issuer_pkg.sv
// alu_cmd_issuer_pkg: shared ALU command types, widths and opcode constants.
package alu_cmd_issuer_pkg;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam logic [CW-1:0] MUL_CMD_A = 4'd9;
  localparam logic [CW-1:0] MUL_CMD_B = 4'd10;
  typedef struct packed {
    logic [1:0]    inp_valid;
    logic          mode;
    logic [CW-1:0] cmd;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic          cin;
  } alu_cmd_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} issue_state_e;
  function automatic logic is_mul(input alu_cmd_t c);
    return c.mode && (c.cmd == MUL_CMD_A || c.cmd == MUL_CMD_B);
  endfunction
endpackage

// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if: valid/ready command channel carrying one ALU command word.
interface alu_cmd_issuer_if;
  import alu_cmd_issuer_pkg::*;
  logic     valid;
  logic     ready;
  alu_cmd_t cmd;
  modport master (output valid, cmd, input ready);
  modport slave  (input valid, cmd, output ready);
endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: DEPTH-entry command FIFO; head word is read out for the issue register.
module alu_cmd_fifo
  import alu_cmd_issuer_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  alu_cmd_t      wdata_i,
  output alu_cmd_t      rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);
  alu_cmd_t      mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q;
  logic          do_push, do_pop;
  assign full_o  = level_q == LW'(DEPTH);
  assign empty_o = level_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];
  assign level_o = level_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= do_push ? wr_q + AW'(1) : wr_q;
      rd_q    <= do_pop ? rd_q + AW'(1) : rd_q;
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands and issues at most one per enabled cycle,
// stalling after multiplies until the ALU's multi-cycle result is done.
module alu_cmd_issuer
  import alu_cmd_issuer_pkg::*;
#(
  parameter  int DEPTH   = 8,
  parameter  int MUL_LAT = 3,
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  alu_cmd_issuer_if.slave   in_if,
  output logic [1:0]        inp_valid_o,
  output logic              mode_o,
  output logic [CW-1:0]     cmd_o,
  output logic [DW-1:0]     opa_o,
  output logic [DW-1:0]     opb_o,
  output logic              cin_o,
  output logic              issue_o,
  output logic [LW-1:0]     level_o,
  output logic              busy_o
);
  localparam int CNTW = $clog2(MUL_LAT + 1);
  issue_state_e    state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  alu_cmd_t        pins_q, pins_d, head;
  logic            issue_q, issue_d, pop, full, empty;
  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_if.valid),
    .pop_i   (pop),
    .wdata_i (in_if.cmd),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_o)
  );
  assign in_if.ready = !full;
  assign pop         = ce_i && state_q != WAIT && !empty;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pins_q  <= '0;
      issue_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pins_q  <= pins_d;
      issue_q <= issue_d;
    end
  end
  // WAIT leaves on the count of 1 so the next pop lands exactly MUL_LAT cycles after the multiply
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ce_i) begin
      if (state_q == WAIT) begin
        cnt_d   = cnt_q - CNTW'(1);
        state_d = cnt_q == CNTW'(1) ? IDLE : WAIT;
      end else if (pop && MUL_LAT > 1 && is_mul(head)) begin
        cnt_d   = CNTW'(MUL_LAT - 1);
        state_d = WAIT;
      end else begin
        state_d = pop ? ISSUE : IDLE;
      end
    end
  end
  always_comb begin
    pins_d  = pins_q;
    issue_d = issue_q;
    if (ce_i) begin
      issue_d = pop;
      pins_d  = pop ? head : pins_q;
      if (!pop) pins_d.inp_valid = 2'b00;
    end
  end
  assign {inp_valid_o, mode_o, cmd_o, opa_o, opb_o, cin_o} = pins_q;
  assign issue_o = issue_q;
  assign busy_o  = !empty || state_q == WAIT;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed and random stimulus against a queue-based issue model.
module tb_alu_cmd_issuer;
  import alu_cmd_issuer_pkg::*;
  localparam int DEPTH = 8;
  localparam int MUL_LAT = 3;
  logic clk = 1'b0, rst = 1'b1, ce = 1'b0;
  logic [1:0] inp_valid;
  logic mode, cin, issue, busy;
  logic [3:0] cmd, level;
  logic [7:0] opa, opb;
  int n_vec = 0, n_bad = 0, cyc = 0;
  int wait_left = 0;
  alu_cmd_t q[$];
  alu_cmd_t exp_pins = '0;
  logic exp_issue = 1'b0;
  int issue_cyc[$];

  alu_cmd_issuer_if in_if ();

  alu_cmd_issuer #(.DEPTH(DEPTH), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .ce_i(ce), .in_if(in_if),
    .inp_valid_o(inp_valid), .mode_o(mode), .cmd_o(cmd), .opa_o(opa), .opb_o(opb),
    .cin_o(cin), .issue_o(issue), .level_o(level), .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic alu_cmd_t mk(input logic [1:0] iv, input logic m, input logic [3:0] c,
                                  input logic [7:0] a, input logic [7:0] b, input logic ci);
    alu_cmd_t r;
    r.inp_valid = iv; r.mode = m; r.cmd = c; r.opa = a; r.opb = b; r.cin = ci;
    return r;
  endfunction

  function automatic alu_cmd_t rnd();
    logic [3:0] c;
    c = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 9) < 3) c = $urandom_range(0, 1) ? 4'd9 : 4'd10;
    return mk(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), c,
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero();
    chk("rst_issue", 32'(issue), 0);
    chk("rst_pins", 32'({inp_valid, mode, cmd, opa, opb, cin}), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ready", 32'(in_if.ready), 1);
    chk("rst_busy", 32'(busy), 0);
  endtask

  // Model: one issue per enabled cycle from the queue head, then MUL_LAT-1 silent enabled cycles after a multiply
  task automatic step(input logic v, input logic c, input alu_cmd_t d);
    logic push;
    in_if.valid = v;
    in_if.cmd   = d;
    ce          = c;
    push = v && q.size() < DEPTH;
    if (c) begin
      if (wait_left == 0 && q.size() > 0) begin
        exp_pins  = q.pop_front();
        exp_issue = 1'b1;
        wait_left = (exp_pins.mode && (exp_pins.cmd == 4'd9 || exp_pins.cmd == 4'd10)) ? MUL_LAT - 1 : 0;
      end else begin
        exp_pins.inp_valid = 2'b00;
        exp_issue = 1'b0;
        if (wait_left > 0) wait_left--;
      end
    end
    if (push) q.push_back(d);
    @(posedge clk);
    #1;
    cyc++;
    chk("issue", 32'(issue), 32'(exp_issue));
    chk("pins", 32'({inp_valid, mode, cmd, opa, opb, cin}), 32'(exp_pins));
    chk("level", 32'(level), 32'(q.size()));
    chk("ready", 32'(in_if.ready), 32'(q.size() < DEPTH));
    chk("busy", 32'(busy), 32'(q.size() > 0 || wait_left > 0));
    if (c && issue) issue_cyc.push_back(cyc);
  endtask

  task automatic do_reset();
    in_if.valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero();
    q.delete();
    wait_left = 0;
    exp_pins  = '0;
    exp_issue = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int n0, span;
    in_if.valid = 1'b0;
    in_if.cmd   = '0;
    #3 check_zero();
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 1'b1, mk(2'b11, 1'b1, 4'd0, 8'h05, 8'h03, 1'b0));
    step(1'b0, 1'b1, '0);
    chk("add_latency", 32'(issue_cyc.size()), 1);
    repeat (2) step(1'b0, 1'b1, '0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, mk(2'b11, 1'b1, 4'(i), 8'(i * 3), 8'(i), 1'b0));
    step(1'b1, 1'b0, mk(2'b11, 1'b0, 4'd5, 8'hEE, 8'hEE, 1'b1));
    chk("full_ready", 32'(in_if.ready), 0);
    n0 = issue_cyc.size();
    repeat (10) step(1'b0, 1'b1, '0);
    chk("burst_cnt", 32'(issue_cyc.size() - n0), 8);
    span = (issue_cyc.size() - n0 == 8) ? issue_cyc[n0 + 7] - issue_cyc[n0] : -1;
    chk("burst_span", 32'(span), 7);
    step(1'b1, 1'b1, mk(2'b11, 1'b1, 4'd9, 8'd3, 8'd4, 1'b0));
    step(1'b1, 1'b1, mk(2'b11, 1'b1, 4'd0, 8'd1, 8'd1, 1'b0));
    n0 = issue_cyc.size();
    repeat (5) step(1'b0, 1'b1, '0);
    span = (issue_cyc.size() - n0 == 1) ? issue_cyc[n0] - issue_cyc[n0 - 1] : -1;
    chk("mul_gap", 32'(span), 3);
    step(1'b1, 1'b1, mk(2'b11, 1'b1, 4'd10, 8'd7, 8'd2, 1'b0));
    step(1'b1, 1'b1, mk(2'b10, 1'b1, 4'd1, 8'd9, 8'd4, 1'b0));
    repeat (4) step(1'b0, 1'b0, '0);
    n0 = issue_cyc.size();
    repeat (5) step(1'b0, 1'b1, '0);
    span = (issue_cyc.size() - n0 == 1) ? issue_cyc[n0] - issue_cyc[n0 - 1] : -1;
    chk("mul_gap_ce", 32'(span), 7);
    step(1'b1, 1'b0, mk(2'b11, 1'b1, 4'd9, 8'd5, 8'd5, 1'b0));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, mk(2'b01, 1'b0, 4'(i), 8'(i), 8'h0F, 1'b0));
    step(1'b0, 1'b1, '0);
    chk("pre_rst_level", 32'(level), 5);
    do_reset();
    n0 = issue_cyc.size();
    repeat (4) step(1'b0, 1'b1, '0);
    chk("post_rst_quiet", 32'(issue_cyc.size() - n0), 0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, mk(2'b11, 1'b0, 4'(i), 8'(i + 16), 8'd0, 1'b0));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, mk(2'b00, 1'b0, 4'(i % 8), 8'(i + 64), 8'd1, 1'b1));
    repeat (12) step(1'b0, 1'b1, '0);
    repeat (400) step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 8), rnd());
    repeat (40) step(1'b0, 1'b1, '0);
    chk("drained", 32'(level), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
